rv_mul_shift_controlpath_param: RTL and testbench

// Parametrised multi-cycle shift/multiply control path for the execute stage.
// It performs SLL/SRL/SRA and MUL (low XLEN bits) on one shared external
// MUL_W x MUL_W multiplier with a variable-latency en/valid handshake.

---
 rtl/rv_mul_shift_controlpath_param.sv | 208 ++++++++++++++++++++
 tb/tb_rv_mul_shift_controlpath_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mul_shift_controlpath_param.sv
`default_nettype none
// ============================================================================
//  Module   : rv_mul_shift_controlpath_param
//  Brief    : Multi-cycle SLL/SRL/SRA/MUL control path for the execute stage.
//             All four operations share one external MUL_W x MUL_W multiplier.
//             A shift by shamt is a multiply by 2^shamt. Right shifts use
//             bit reversal, and SRA also sign-fills the upper bits.
//             A full-width product is built from three partial products.
//  Revision : 1.0 - initial release
// ============================================================================
module rv_mul_shift_controlpath_param #(
    parameter int XLEN  = 32,
    parameter int MUL_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_execute_en,
    input  logic [2:0]           i_execute_shifter_opcode,
    input  logic [XLEN-1:0]      i_execute_operand_one,
    input  logic [XLEN-1:0]      i_execute_operand_two,
    output logic                 o_execute_data_valid,
    output logic [XLEN-1:0]      o_execute_data_result,
    output logic                 o_execute_illegal,
    output logic                 o_busy,
    output logic                 o_multiplier_en,
    output logic [MUL_W-1:0]     o_multiplier_operand_one,
    output logic [MUL_W-1:0]     o_multiplier_operand_two,
    input  logic                 i_multiplier_valid,
    input  logic [2*MUL_W-1:0]   i_multiplier_result
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [2:0] c_OP_MUL = 3'b000;
    localparam logic [2:0] c_OP_SLL = 3'b001;
    localparam logic [2:0] c_OP_SRL = 3'b101;
    localparam logic [2:0] c_OP_SRA = 3'b110;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_REQ  = 3'd1;
    localparam logic [2:0] c_ST_ACC  = 3'd2;
    localparam logic [2:0] c_ST_FIN  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    localparam logic [XLEN-1:0] c_ONE  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] c_ONES = {XLEN{1'b1}};

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic               r_armed;
    logic [2:0]         r_op;
    logic [XLEN-1:0]    r_a;
    logic [SHW-1:0]     r_shamt;
    logic [XLEN-1:0]    r_x;
    logic [XLEN-1:0]    r_y;
    logic [1:0]         r_k;
    logic [2*MUL_W-1:0] r_prod;
    logic [XLEN-1:0]    r_acc;
    logic [XLEN-1:0]    r_result;
    logic               r_illegal;

    logic               w_accept;
    logic               w_legal;
    logic               w_is_shift;
    logic               w_is_right;
    logic               w_bypass;
    logic [SHW-1:0]     w_shamt;
    logic [XLEN-1:0]    w_acc_rev;
    logic [XLEN-1:0]    w_fin_result;

    function automatic logic [XLEN-1:0] f_bitrev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

    // Request decode. Only the low SHW bits of B form the shift amount.
    always_comb begin
        w_shamt    = i_execute_operand_two[SHW-1:0];
        w_is_shift = (i_execute_shifter_opcode == c_OP_SLL) ||
                     (i_execute_shifter_opcode == c_OP_SRL) ||
                     (i_execute_shifter_opcode == c_OP_SRA);
        w_is_right = (i_execute_shifter_opcode == c_OP_SRL) ||
                     (i_execute_shifter_opcode == c_OP_SRA);
        w_legal    = w_is_shift || (i_execute_shifter_opcode == c_OP_MUL);
        w_bypass   = !w_legal || (w_is_shift && (w_shamt == '0));
        w_accept   = (r_state == c_ST_IDLE) && i_execute_en && r_armed;
    end

    // Final result. Right shifts undo the bit reversal, and SRA fills the vacated top bits.
    always_comb begin
        w_acc_rev = f_bitrev(r_acc);
        case (r_op)
            c_OP_SRL: w_fin_result = w_acc_rev;
            c_OP_SRA: w_fin_result = w_acc_rev |
                                     (r_a[XLEN-1] ? ~(c_ONES >> r_shamt) : '0);
            default:  w_fin_result = r_acc;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. There are three multiply/accumulate rounds, one per partial product.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_next_state = w_bypass ? c_ST_DONE : c_ST_REQ;
            c_ST_REQ:  if (i_multiplier_valid) w_next_state = c_ST_ACC;
            c_ST_ACC:  w_next_state = (r_k == 2'd2) ? c_ST_FIN : c_ST_REQ;
            c_ST_FIN:  w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Datapath. This covers operand latch, product capture, accumulation and the result register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_armed   <= 1'b1;
            r_op      <= '0;
            r_a       <= '0;
            r_shamt   <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_k       <= '0;
            r_prod    <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (!i_execute_en) begin
                r_armed <= 1'b1;
            end

            if (w_accept) begin
                r_op      <= i_execute_shifter_opcode;
                r_a       <= i_execute_operand_one;
                r_shamt   <= w_shamt;
                r_k       <= '0;
                r_acc     <= '0;
                r_illegal <= !w_legal;
                r_x       <= w_is_right ? f_bitrev(i_execute_operand_one)
                                        : i_execute_operand_one;
                r_y       <= (i_execute_shifter_opcode == c_OP_MUL) ? i_execute_operand_two
                                                                    : (c_ONE << w_shamt);
                if (w_bypass) begin
                    r_result <= w_legal ? i_execute_operand_one : '0;
                end
            end

            if ((r_state == c_ST_REQ) && i_multiplier_valid) begin
                r_prod <= i_multiplier_result;
            end

            if (r_state == c_ST_ACC) begin
                r_acc <= (r_k == 2'd0) ? r_prod : (r_acc + (r_prod << MUL_W));
                r_k   <= r_k + 2'd1;
            end

            if (r_state == c_ST_FIN) begin
                r_result <= w_fin_result;
            end
        end
    end

    // Outputs. The partial-product operand pairs are XL*YL, XH*YL and XL*YH.
    always_comb begin
        o_execute_data_valid     = (r_state == c_ST_DONE);
        o_execute_illegal        = (r_state == c_ST_DONE) && r_illegal;
        o_busy                   = (r_state != c_ST_IDLE);
        o_multiplier_en          = (r_state == c_ST_REQ);
        o_execute_data_result    = r_result;
        o_multiplier_operand_one = '0;
        o_multiplier_operand_two = '0;
        if (r_state == c_ST_REQ) begin
            case (r_k)
                2'd0: begin
                    o_multiplier_operand_one = r_x[MUL_W-1:0];
                    o_multiplier_operand_two = r_y[MUL_W-1:0];
                end
                2'd1: begin
                    o_multiplier_operand_one = r_x[XLEN-1:MUL_W];
                    o_multiplier_operand_two = r_y[MUL_W-1:0];
                end
                2'd2: begin
                    o_multiplier_operand_one = r_x[MUL_W-1:0];
                    o_multiplier_operand_two = r_y[XLEN-1:MUL_W];
                end
                default: begin
                    o_multiplier_operand_one = '0;
                    o_multiplier_operand_two = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_mul_shift_controlpath_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_mul_shift_controlpath_param
//  Brief    : Directed self-checking bench with a variable-latency multiplier model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv_mul_shift_controlpath_param;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic        valid, illegal, busy, mul_en, mul_valid;
    logic [31:0] result, mul_result;
    logic [15:0] mul_x, mul_y;

    int tests = 0;
    int fails = 0;

    int mul_lat    = 1;
    bit force_valid = 1'b0;
    int n_cyc = 0;

    int   en_rises = 0;
    int   stab_err = 0;
    int   vcount   = 0;
    logic prev_en  = 1'b0;
    logic [15:0] px = '0, py = '0;

    always #5 clk = ~clk;

    rv_mul_shift_controlpath_param #(.XLEN(32), .MUL_W(16)) dut (
        .i_clk                    (clk),
        .i_rst                    (rst),
        .i_execute_en             (en),
        .i_execute_shifter_opcode (op),
        .i_execute_operand_one    (opa),
        .i_execute_operand_two    (opb),
        .o_execute_data_valid     (valid),
        .o_execute_data_result    (result),
        .o_execute_illegal        (illegal),
        .o_busy                   (busy),
        .o_multiplier_en          (mul_en),
        .o_multiplier_operand_one (mul_x),
        .o_multiplier_operand_two (mul_y),
        .i_multiplier_valid       (mul_valid),
        .i_multiplier_result      (mul_result)
    );

    // Multiplier model: product pulses in the mul_lat-th cycle of a request.
    always @(negedge clk) begin
        if (force_valid) begin
            mul_valid  <= 1'b1;
            mul_result <= 32'hDEAD_BEEF;
        end else if (mul_en) begin
            if (n_cyc + 1 == mul_lat) begin
                mul_valid  <= 1'b1;
                mul_result <= 32'(mul_x) * 32'(mul_y);
                n_cyc      <= 0;
            end else begin
                mul_valid  <= 1'b0;
                n_cyc      <= n_cyc + 1;
            end
        end else begin
            mul_valid <= 1'b0;
            n_cyc     <= 0;
        end
    end

    // Monitor: counts request rises, operand changes under request, and valid cycles.
    always @(negedge clk) begin
        if (mul_en && !prev_en) en_rises <= en_rises + 1;
        if (mul_en && prev_en && ((mul_x != px) || (mul_y != py))) stab_err <= stab_err + 1;
        if (valid) vcount <= vcount + 1;
        prev_en <= mul_en;
        px      <= mul_x;
        py      <= mul_y;
    end

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ill, output int lat);
        @(negedge clk);
        en = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        en = 1'b0;
        lat = 1;
        while (!valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        ill = illegal;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; op = '0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (mul_en !== 1'b0) begin fails++; $display("FAIL reset_mul_en: got %b want 0", mul_en); end
        tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 0", result); end
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        tests++; if ({mul_x, mul_y} !== 32'h0) begin fails++; $display("FAIL reset_operands: got %h want 0", {mul_x, mul_y}); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_sll();
        logic [31:0] r; logic il; int lat; int e0;
        mul_lat = 1;
        e0 = en_rises;
        do_op(3'b001, 32'h0010_4F82, 32'd12, r, il, lat);
        tests++; if (r !== 32'h04F8_2000) begin fails++; $display("FAIL sll_result: got %h want %h", r, 32'h04F8_2000); end
        tests++; if (il !== 1'b0) begin fails++; $display("FAIL sll_illegal: got %b want 0", il); end
        tests++; if (lat != 8) begin fails++; $display("FAIL sll_latency: got %0d want 8", lat); end
        tests++; if (valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL sll_pulse_end: got valid=%b busy=%b want 0 0", valid, busy); end
        tests++; if (en_rises - e0 != 3) begin fails++; $display("FAIL sll_en_pulses: got %0d want 3", en_rises - e0); end
    endtask

    task automatic test_srl_sra();
        logic [31:0] r; logic il; int lat;
        mul_lat = 2;
        do_op(3'b101, 32'hF104_0F82, 32'd12, r, il, lat);
        tests++; if (r !== 32'h000F_1040) begin fails++; $display("FAIL srl_result: got %h want %h", r, 32'h000F_1040); end
        do_op(3'b110, 32'hF104_0F82, 32'd12, r, il, lat);
        tests++; if (r !== 32'hFFFF_1040) begin fails++; $display("FAIL sra_result: got %h want %h", r, 32'hFFFF_1040); end
        tests++; if (lat != 11) begin fails++; $display("FAIL sra_latency: got %0d want 11", lat); end
        do_op(3'b101, 32'hF104_0F82, 32'h0000_010C, r, il, lat);
        tests++; if (r !== 32'h000F_1040) begin fails++; $display("FAIL srl_upper_b: got %h want %h", r, 32'h000F_1040); end
        do_op(3'b110, 32'hF104_0F82, 32'h0000_010C, r, il, lat);
        tests++; if (r !== 32'hFFFF_1040) begin fails++; $display("FAIL sra_upper_b: got %h want %h", r, 32'hFFFF_1040); end
        do_op(3'b110, 32'h7104_0F82, 32'd4, r, il, lat);
        tests++; if (r !== 32'h0710_40F8) begin fails++; $display("FAIL sra_positive: got %h want %h", r, 32'h0710_40F8); end
    endtask

    task automatic test_mul(input int l);
        logic [31:0] r; logic il; int lat; int e0; int s0;
        mul_lat = l;
        e0 = en_rises; s0 = stab_err;
        do_op(3'b000, 32'h0001_0003, 32'h0002_0005, r, il, lat);
        tests++; if (r !== 32'h000B_000F) begin fails++; $display("FAIL mul_small_L%0d: got %h want %h", l, r, 32'h000B_000F); end
        tests++; if (lat != 3 * (l + 1) + 2) begin fails++; $display("FAIL mul_latency_L%0d: got %0d want %0d", l, lat, 3 * (l + 1) + 2); end
        tests++; if (en_rises - e0 != 3) begin fails++; $display("FAIL mul_en_pulses_L%0d: got %0d want 3", l, en_rises - e0); end
        tests++; if (stab_err != s0) begin fails++; $display("FAIL mul_operand_stable_L%0d: got %0d changes want 0", l, stab_err - s0); end
        do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, il, lat);
        tests++; if (r !== 32'h0000_0001) begin fails++; $display("FAIL mul_wrap_L%0d: got %h want 1", l, r); end
        tests++; if (il !== 1'b0) begin fails++; $display("FAIL mul_illegal_L%0d: got %b want 0", l, il); end
    endtask

    task automatic test_bypass();
        logic [31:0] r; logic il; int lat; int e0;
        e0 = en_rises;
        do_op(3'b001, 32'h1234_5678, 32'd0, r, il, lat);
        tests++; if (r !== 32'h1234_5678) begin fails++; $display("FAIL bypass_sll_result: got %h want %h", r, 32'h1234_5678); end
        tests++; if (lat != 1) begin fails++; $display("FAIL bypass_sll_latency: got %0d want 1", lat); end
        do_op(3'b110, 32'h8000_0001, 32'h0000_0020, r, il, lat);
        tests++; if (r !== 32'h8000_0001) begin fails++; $display("FAIL bypass_sra_result: got %h want %h", r, 32'h8000_0001); end
        tests++; if (en_rises != e0) begin fails++; $display("FAIL bypass_no_en: got %0d rises want 0", en_rises - e0); end
    endtask

    task automatic test_illegal();
        logic [31:0] r; logic il; int lat; int e0;
        e0 = en_rises;
        do_op(3'b011, 32'hABCD_EF01, 32'd5, r, il, lat);
        tests++; if (r !== 32'h0) begin fails++; $display("FAIL illegal_result: got %h want 0", r); end
        tests++; if (il !== 1'b1) begin fails++; $display("FAIL illegal_flag: got %b want 1", il); end
        tests++; if (lat != 1) begin fails++; $display("FAIL illegal_latency: got %0d want 1", lat); end
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL illegal_pulse_end: got %b want 0", illegal); end
        tests++; if (en_rises != e0) begin fails++; $display("FAIL illegal_no_en: got %0d rises want 0", en_rises - e0); end
    endtask

    task automatic test_back_to_back();
        int v0;
        mul_lat = 1;
        v0 = vcount;
        @(negedge clk); en = 1'b1; op = 3'b001; opa = 32'd1; opb = 32'd4;
        repeat (30) @(negedge clk);
        tests++; if (vcount - v0 != 1) begin fails++; $display("FAIL held_en_ops: got %0d valid pulses want 1", vcount - v0); end
        tests++; if (result !== 32'h10) begin fails++; $display("FAIL held_en_result: got %h want 10", result); end
        en = 1'b0;
        @(negedge clk); en = 1'b1; opa = 32'd3; opb = 32'd1;
        v0 = vcount;
        repeat (30) @(negedge clk);
        en = 1'b0;
        tests++; if (vcount - v0 != 1) begin fails++; $display("FAIL rearm_ops: got %0d valid pulses want 1", vcount - v0); end
        tests++; if (result !== 32'h6) begin fails++; $display("FAIL rearm_result: got %h want 6", result); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r; logic il; int lat; int w; int v0;
        mul_lat = 4;
        @(negedge clk); en = 1'b1; op = 3'b000; opa = 32'd7; opb = 32'd9;
        @(posedge clk); #1; en = 1'b0;
        w = 0;
        while (!mul_en && w < 10) begin @(posedge clk); #1; w++; end
        tests++; if (mul_en !== 1'b1) begin fails++; $display("FAIL midrst_reach_req: got en=%b want 1", mul_en); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        tests++; if (mul_en !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
            fails++; $display("FAIL midrst_outputs: got en=%b busy=%b valid=%b want 0 0 0", mul_en, busy, valid); end
        tests++; if (result !== 32'h0) begin fails++; $display("FAIL midrst_result: got %h want 0", result); end
        @(negedge clk); rst = 1'b0;
        v0 = vcount;
        @(posedge clk); #1;
        @(posedge clk); #1; force_valid = 1'b1;
        @(posedge clk); #1; force_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        tests++; if (vcount != v0 || busy !== 1'b0) begin
            fails++; $display("FAIL midrst_late_valid: got pulses=%0d busy=%b want 0 0", vcount - v0, busy); end
        mul_lat = 1;
        do_op(3'b000, 32'd7, 32'd9, r, il, lat);
        tests++; if (r !== 32'd63) begin fails++; $display("FAIL midrst_next_op: got %h want %h", r, 32'd63); end
        tests++; if (lat != 8) begin fails++; $display("FAIL midrst_next_latency: got %0d want 8", lat); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; op = '0; opa = '0; opb = '0;
        test_reset();
        test_sll();
        test_srl_sra();
        test_mul(1);
        test_mul(4);
        test_bypass();
        test_illegal();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
